cache_req_responder: RTL

//  Responder end of the core->cache request interface (cache_req/cache_rw/cache_addr/cache_data_out).

---
 rtl/cache_req_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/cache_req_responder.sv
// Responder end of the core->cache request interface. Round-robin arbitration over level-held
// requests, one access in flight against a small word-addressed store with fixed latency.
module cache_req_responder #(
    parameter int unsigned NUM_CORES  = 2,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned LATENCY    = 3
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_CORES-1:0]   core_req,
    input  logic [NUM_CORES-1:0]   core_rw,
    input  logic [NUM_CORES*32-1:0] core_addr,
    input  logic [NUM_CORES*32-1:0] core_wdata,
    output logic [NUM_CORES-1:0]   core_ack,
    output logic [31:0]            resp_rdata,
    output logic                   resp_err,
    output logic                   busy
);

    localparam int unsigned IdxW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int unsigned CntW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int unsigned Depth = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [IdxW-1:0]        gnt_q, gnt_d;
    logic [IdxW-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   rw_q, rw_d;
    logic [31:0]            addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [NUM_CORES-1:0]   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic [31:0]            mem_q [Depth];

    logic                   gnt_valid;
    logic [IdxW-1:0]        gnt_idx;
    int unsigned            cand;
    logic [DEPTH_LOG2-1:0]  mem_idx;
    logic                   misaligned;
    logic                   mem_we;

    // Upper address bits only alias the store; they are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_q[31:DEPTH_LOG2+2];

    assign mem_idx    = addr_q[2 +: DEPTH_LOG2];
    assign misaligned = (addr_q[1:0] != 2'b00);

    assign core_ack   = ack_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign busy       = (state_q != StIdle);

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NUM_CORES; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_CORES;
            if (!gnt_valid && core_req[cand]) begin
                gnt_valid = 1'b1;
                gnt_idx   = IdxW'(cand);
            end
        end
    end

    // Next-state, request latching and response generation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ack_d    = ack_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    gnt_d    = gnt_idx;
                    rw_d     = core_rw[gnt_idx];
                    addr_d   = core_addr[32'(gnt_idx) * 32 +: 32];
                    wdata_d  = core_wdata[32'(gnt_idx) * 32 +: 32];
                    cnt_d    = CntW'(LATENCY - 1);
                    rr_ptr_d = IdxW'((32'(gnt_idx) + 1) % NUM_CORES);
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    ack_d   = NUM_CORES'(1) << gnt_q;
                    err_d   = misaligned;
                    rdata_d = (rw_q || misaligned) ? 32'h0 : mem_q[mem_idx];
                    mem_we  = rw_q && !misaligned;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone: begin
                // Requests are not sampled here; the core reacts to its ack first.
                ack_d   = '0;
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Backing store; written on the ack edge of an aligned write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= wdata_q;
        end
    end

endmodule
